// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Memory geometry mirrors the core's instruction ROM; BPW is derived from the word width.
package imem_loader_pkg;

  localparam int AWIDTH = 4;
  localparam int DWIDTH = 32;
  localparam int WORDS  = 16;
  localparam int BPW    = DWIDTH / 8;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into DWIDTH-bit words.
// The word output is combinational so the completing byte and the word appear in the same cycle.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DWIDTH-1:0] word,
  output logic              word_ready
);

  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

  // Only the first BPW-1 bytes are stored; the last one is taken straight from byte_in.
  logic [DWIDTH-9:0] sr_q, sr_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  assign word       = {byte_in, sr_q};
  assign word_ready = shift_en && (idx_q == IDXW'(BPW - 1));

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (shift_en) begin
      sr_d  = {byte_in, sr_q[DWIDTH-9:8]};
      idx_d = word_ready ? '0 : idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length header, writes packed words to the instruction ROM
// and verifies a trailing XOR checksum of all data bytes.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               rx_ready_q, rx_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [AWIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DWIDTH-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer;
  logic               asm_clr;
  logic               asm_shift;
  logic [DWIDTH-1:0]  asm_word;
  logic               asm_ready;
  logic [LEN_W-1:0]   len_full;

  assign xfer      = rx_valid && rx_ready_q;
  assign asm_clr   = (state_q == ST_IDLE) && start;
  assign asm_shift = xfer && (state_q == ST_DATA);
  assign len_full  = {rx_data, len_q[7:0]};

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .shift_en   (asm_shift),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN0;
          err_d   = 1'b0;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          if (len_full == '0) begin
            state_d = ST_CSUM;
          end else if (len_full > LEN_W'(WORDS)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (asm_ready) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[AWIDTH-1:0];
            wr_data_d = asm_word;
            cnt_d     = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they line up with it.
    rx_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CSUM);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected ROM writes are queued as streams are driven
// and checked against every wr_en strobe; status flags are checked at fixed cycle offsets.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  sb[$];
  int   wr_cycles[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  logic [7:0] img_good[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
  logic [7:0] img_bad[$]   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
  logic [7:0] img_big[$]   = '{8'h11, 8'h00};
  logic [7:0] img_zero[$]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] img_part[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};

  imem_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: each strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected=no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", wr_data, e.d);
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bs[$], input int gap);
    int w;
    for (int i = 0; i < bs.size(); i++) begin
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      rx_data  = bs[i];
      rx_valid = 1'b1;
      w = 0;
      while (!rx_ready && w < 20) begin
        tick();
        w++;
      end
      if (!rx_ready) begin
        checks++;
        errors++;
        $error("FAIL rx_ready_timeout observed=0 expected=1");
        break;
      end
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic push_good_writes();
    sb.push_back('{a: 4'd0, d: 32'h0000_0013});
    sb.push_back('{a: 4'd1, d: 32'h0000_006F});
  endtask

  task automatic run_good(input string tag, input int gap);
    int d0;
    d0 = done_cnt;
    wr_cycles.delete();
    push_good_writes();
    pulse_start();
    check({tag, "_rx_ready_after_start"}, 32'(rx_ready), 32'd1);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    send_stream(img_good, gap);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_write_count"}, 32'(wr_cycles.size()), 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();

    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two-word image, rx_valid held high.
    run_good("good", 0);
    if (wr_cycles.size() == 2)
      check("good_write_spacing", 32'(wr_cycles[1] - wr_cycles[0]), 32'd4);

    // Same image with a corrupted checksum byte.
    d0 = done_cnt;
    push_good_writes();
    pulse_start();
    send_stream(img_bad, 0);
    check("badcs_err", 32'(err), 32'd1);
    check("badcs_busy", 32'(busy), 32'd0);
    check("badcs_done", 32'(done), 32'd0);
    tick();
    check("badcs_err_sticky", 32'(err), 32'd1);
    check("badcs_done_count", 32'(done_cnt - d0), 32'd0);
    check("badcs_writes_left", 32'(sb.size()), 32'd0);

    // Header announcing WORDS+1 words; start must also clear the old error.
    pulse_start();
    check("big_err_cleared", 32'(err), 32'd0);
    send_stream(img_big, 0);
    check("big_err", 32'(err), 32'd1);
    check("big_rx_ready", 32'(rx_ready), 32'd0);
    check("big_busy", 32'(busy), 32'd0);
    tick();
    check("big_wr_en", 32'(wr_en), 32'd0);

    // Empty image; a start arriving in the DONE cycle must be ignored.
    d0 = done_cnt;
    pulse_start();
    send_stream(img_zero, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    pulse_start();
    check("zero_start_in_done_busy", 32'(busy), 32'd0);
    check("zero_start_in_done_ready", 32'(rx_ready), 32'd0);
    check("zero_done_count", 32'(done_cnt - d0), 32'd1);
    tick();
    check("zero_still_idle", 32'(busy), 32'd0);

    // Gapped source.
    run_good("gap", 1);

    // Reset after three data bytes, then a clean reload from address 0.
    pulse_start();
    send_stream(img_part, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    run_good("reload", 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
